// File: rtl/program_sequencer_pkg.sv
// Shared types for the program sequencer: the opcode encoding used by the
// program memory image, and the sequencer state set.
package program_sequencer_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        NOP      = 4'd0,
        ADD      = 4'd1,
        LOAD     = 4'd2,
        STOREMEM = 4'd3,
        STORERF  = 4'd4,
        JUMP     = 4'd5,
        HALT     = 4'd6
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } seq_state_t;

endpackage

// File: rtl/program_sequencer_if.sv
// Program-memory fetch port plus the valid/ready op channel to the datapath.
interface program_sequencer_if #(
    parameter int BITS_FOR_INSTRUCTIONS = 5,
    parameter int INSTRUCTION_WIDTH     = 16,
    parameter int OPCODE_WIDTH          = 4
);
    logic [BITS_FOR_INSTRUCTIONS-1:0]          instruction_address;
    logic [INSTRUCTION_WIDTH-1:0]              instruction;
    logic                                      op_valid;
    logic                                      op_ready;
    logic [OPCODE_WIDTH-1:0]                   opcode;
    logic [INSTRUCTION_WIDTH-OPCODE_WIDTH-1:0] operand;

    modport master (
        output instruction_address, op_valid, opcode, operand,
        input  instruction, op_ready
    );

    modport slave (
        input  instruction_address, op_valid, opcode, operand,
        output instruction, op_ready
    );
endinterface

// File: rtl/program_sequencer.sv
// Steps the PC through program memory: FETCH loads the IR, ISSUE resolves
// NOP/JUMP/HALT locally and hands every other opcode to the datapath.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int BITS_FOR_INSTRUCTIONS = 5,
    parameter int INSTRUCTION_WIDTH     = 16,
    parameter int OPCODE_WIDTH          = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    program_sequencer_if.master bus,
    output logic                busy,
    output logic                halted
);

    seq_state_t                       state, state_next;
    logic [BITS_FOR_INSTRUCTIONS-1:0] pc, pc_next;
    logic [INSTRUCTION_WIDTH-1:0]     ir, ir_next;
    logic [OPCODE_WIDTH-1:0]          ir_op;
    logic                             op_valid;

    assign ir_op = ir[OPCODE_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ir    <= ir_next;
        end
    end

    // The if/else chain (rather than a case) sends an X opcode to the
    // datapath branch, so unknown words are issued instead of silently skipped.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        op_valid   = 1'b0;
        case (state)
            IDLE, HALTED: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                ir_next    = bus.instruction;
                state_next = ISSUE;
            end
            ISSUE: begin
                if (ir_op == OPCODE_WIDTH'(NOP)) begin
                    pc_next    = pc + 1'b1;
                    state_next = FETCH;
                end else if (ir_op == OPCODE_WIDTH'(JUMP)) begin
                    pc_next    = ir[OPCODE_WIDTH +: BITS_FOR_INSTRUCTIONS];
                    state_next = FETCH;
                end else if (ir_op == OPCODE_WIDTH'(HALT)) begin
                    state_next = HALTED;
                end else begin
                    op_valid = 1'b1;
                    if (bus.op_ready) begin
                        pc_next    = pc + 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.instruction_address = pc;
    assign bus.op_valid            = op_valid;
    assign bus.opcode              = ir[OPCODE_WIDTH-1:0];
    assign bus.operand             = ir[INSTRUCTION_WIDTH-1:OPCODE_WIDTH];
    assign busy                    = (state == FETCH) || (state == ISSUE);
    assign halted                  = (state == HALTED);

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench: decode vector table, hand-written corner sequences and
// random programs checked against an instruction-level interpreter.
module tb_program_sequencer;
    import program_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy, halted;
    logic [15:0] mem [32];

    int checks = 0;
    int errors = 0;

    program_sequencer_if #(
        .BITS_FOR_INSTRUCTIONS(5),
        .INSTRUCTION_WIDTH(16),
        .OPCODE_WIDTH(4)
    ) bus ();

    program_sequencer #(
        .BITS_FOR_INSTRUCTIONS(5),
        .INSTRUCTION_WIDTH(16),
        .OPCODE_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bus(bus),
        .busy(busy),
        .halted(halted)
    );

    always #5 clk = ~clk;

    assign bus.instruction = mem[bus.instruction_address];

    typedef struct {
        logic [4:0]  pc;
        logic [15:0] word;
    } exp_t;

    exp_t       exp_q[$];
    bit         exp_halts;
    logic [4:0] exp_halt_pc;
    int         exp_instr;

    typedef struct {
        logic [15:0] word;
        logic        ready;
        logic        exp_valid;
        logic [4:0]  exp_addr;
        logic        exp_busy;
        logic        exp_halted;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        bus.op_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_nop();
        for (int a = 0; a < 32; a++) mem[a] = 16'(NOP);
    endtask

    // Executes the program as an instruction stream, ignoring timing.
    function automatic void interpret(input int max_steps);
        logic [4:0]  p;
        logic [15:0] w;
        exp_t        e;
        p = '0;
        exp_q.delete();
        exp_halts = 1'b0;
        exp_halt_pc = '0;
        exp_instr = 0;
        for (int s = 0; s < max_steps; s++) begin
            w = mem[p];
            exp_instr++;
            if (w[3:0] == 4'(NOP)) begin
                p = p + 5'd1;
            end else if (w[3:0] == 4'(JUMP)) begin
                p = w[8:4];
            end else if (w[3:0] == 4'(HALT)) begin
                exp_halts = 1'b1;
                exp_halt_pc = p;
                return;
            end else begin
                e.pc = p;
                e.word = w;
                exp_q.push_back(e);
                p = p + 5'd1;
            end
        end
    endfunction

    // Starts the program and scoreboards every issued op; a halting program
    // must take 2 cycles per instruction plus one per stall cycle.
    task automatic run_program(input bit rand_ready, input int budget, input int max_steps);
        int cyc;
        int stalls;
        bit halted_seen;
        bit busy_ok;
        interpret(max_steps);
        stalls = 0;
        cyc = 0;
        halted_seen = 1'b0;
        busy_ok = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        while (cyc < budget) begin
            @(negedge clk);
            start = 1'b0;
            if (halted) begin
                halted_seen = 1'b1;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            bus.op_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.op_valid) begin
                if (exp_q.size() == 0) begin
                    chk("extra_op", 32'd1, 32'd0);
                    break;
                end
                chk("op_pc", 32'(bus.instruction_address), 32'(exp_q[0].pc));
                chk("op_word", 32'({bus.operand, bus.opcode}), 32'(exp_q[0].word));
                if (bus.op_ready) void'(exp_q.pop_front());
                else stalls++;
            end
            if (!exp_halts && exp_q.size() == 0) break;
            @(posedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("ops_remaining", 32'(exp_q.size()), 32'd0);
        chk("busy_while_running", 32'(busy_ok), 32'd1);
        if (exp_halts) begin
            chk("halted_reached", 32'(halted_seen), 32'd1);
            chk("halt_cycles", 32'(cyc), 32'(2 * exp_instr + stalls));
            chk("halt_pc", 32'(bus.instruction_address), 32'(exp_halt_pc));
        end
    endtask

    initial begin
        vecs[0] = '{16'h0000, 1'b1, 1'b0, 5'd1,  1'b1, 1'b0};
        vecs[1] = '{16'h0145, 1'b1, 1'b0, 5'd20, 1'b1, 1'b0};
        vecs[2] = '{16'hFF35, 1'b1, 1'b0, 5'd19, 1'b1, 1'b0};
        vecs[3] = '{16'h0006, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1};
        vecs[4] = '{16'hABC1, 1'b1, 1'b1, 5'd1,  1'b1, 1'b0};
        vecs[5] = '{16'h1231, 1'b0, 1'b1, 5'd0,  1'b1, 1'b0};
        vecs[6] = '{16'h3F52, 1'b1, 1'b1, 5'd1,  1'b1, 1'b0};
        vecs[7] = '{16'h555F, 1'b1, 1'b1, 5'd1,  1'b1, 1'b0};
        vecs[8] = '{16'h0017, 1'b0, 1'b1, 5'd0,  1'b1, 1'b0};

        bus.op_ready = 1'b0;
        fill_nop();
        rst = 1'b1;
        #12;
        chk("reset_op_valid", 32'(bus.op_valid), 32'd0);
        chk("reset_ir_fields", 32'({bus.operand, bus.opcode}), 32'd0);
        chk("reset_addr", 32'(bus.instruction_address), 32'd0);
        chk("reset_busy_halted", 32'({busy, halted}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single-instruction decode table
        for (int i = 0; i < 9; i++) begin
            do_reset();
            fill_nop();
            mem[0] = vecs[i].word;
            @(negedge clk);
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            @(posedge clk);
            @(negedge clk);
            bus.op_ready = vecs[i].ready;
            chk($sformatf("vec%0d_valid", i), 32'(bus.op_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_fields", i), 32'({bus.operand, bus.opcode}), 32'(vecs[i].word));
            @(negedge clk);
            chk($sformatf("vec%0d_addr", i), 32'(bus.instruction_address), 32'(vecs[i].exp_addr));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].exp_halted));
        end

        // ADD, ADD, HALT with ready held high
        do_reset();
        fill_nop();
        mem[0] = 16'(ADD);
        mem[1] = 16'(ADD);
        mem[2] = 16'(HALT);
        run_program(1'b0, 40, 60);

        // LOAD stalled three cycles, operand held stable
        do_reset();
        fill_nop();
        mem[0] = {12'h3F5, 4'(LOAD)};
        mem[1] = 16'(HALT);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.op_ready = (i == 3);
            chk("stall_valid", 32'(bus.op_valid), 32'd1);
            chk("stall_operand", 32'(bus.operand), 32'h3F5);
            chk("stall_pc", 32'(bus.instruction_address), 32'd0);
        end
        @(negedge clk);
        chk("stall_pc_after", 32'(bus.instruction_address), 32'd1);
        chk("stall_valid_after", 32'(bus.op_valid), 32'd0);

        // JUMP to 20, STORERF, HALT
        do_reset();
        fill_nop();
        mem[0]  = {12'd20, 4'(JUMP)};
        mem[20] = {12'h0A5, 4'(STORERF)};
        mem[21] = 16'(HALT);
        run_program(1'b0, 40, 60);

        // NOP sweep with ADD at the last address: two laps, PC wraps
        do_reset();
        fill_nop();
        mem[31] = {12'h777, 4'(ADD)};
        run_program(1'b0, 200, 64);

        // Asynchronous reset during a pending handshake
        do_reset();
        fill_nop();
        mem[0] = 16'(ADD);
        mem[1] = 16'(HALT);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.op_ready = 1'b0;
        chk("rst_pre_valid", 32'(bus.op_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(bus.op_valid), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_addr", 32'(bus.instruction_address), 32'd0);
        chk("rst_async_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_program(1'b0, 40, 60);

        // start ignored while busy, honoured from HALTED
        do_reset();
        fill_nop();
        mem[0] = 16'(ADD);
        mem[1] = 16'(ADD);
        mem[2] = 16'(HALT);
        bus.op_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_addr", 32'(bus.instruction_address), 32'd1);
        chk("busy_start_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 20 && !halted; i++) @(negedge clk);
        chk("restart_pre_halted", 32'(halted), 32'd1);
        chk("restart_pre_addr", 32'(bus.instruction_address), 32'd2);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("restart_halted", 32'(halted), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_addr", 32'(bus.instruction_address), 32'd0);

        // Random programs with random backpressure
        for (int t = 0; t < 20; t++) begin
            do_reset();
            for (int a = 0; a < 32; a++) begin
                int r;
                logic [3:0] op;
                r = $urandom_range(0, 19);
                if (r < 3) op = 4'(NOP);
                else if (r == 3) op = 4'(JUMP);
                else if (r == 4) op = 4'(HALT);
                else if (r < 8) op = 4'($urandom_range(7, 15));
                else op = 4'($urandom_range(1, 4));
                mem[a] = {12'($urandom), op};
            end
            run_program(1'b1, 400, 60);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
